// File: rtl/vram_pkg.sv
// Shared widths and read-tag encoding for the video RAM arbiter.
package vram_pkg;

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned VGA_LAT = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TAG_W   = 2;

  // Read tags are {is_vga, is_cpu}
  localparam logic [TAG_W-1:0] TAG_NONE = 2'b00;
  localparam logic [TAG_W-1:0] TAG_VGA  = 2'b10;
  localparam logic [TAG_W-1:0] TAG_CPU  = 2'b01;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/vram_if.sv
// Bundle of the vga fetch, CPU bus and RAM-side signals around the arbiter.
interface vram_if;
  import vram_pkg::*;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vga_data, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata, conflict_cnt
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vga_data, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata, conflict_cnt
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// Two-stage read-tag shift that steers RAM read data to the vga or CPU
// output register and generates the one-cycle cpu_ack.
module vram_rd_pipe
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  tag,
  input  logic              wr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] vga_data,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack
);

  logic [TAG_W-1:0] tag_s1;
  logic [TAG_W-1:0] tag_s2;
  logic             wr_s1;

  // Writes complete one stage earlier than reads since no data comes back
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s1    <= TAG_NONE;
      tag_s2    <= TAG_NONE;
      wr_s1     <= 1'b0;
      vga_data  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      tag_s1  <= tag;
      tag_s2  <= tag_s1;
      wr_s1   <= wr;
      cpu_ack <= wr_s1 | (tag_s2 == TAG_CPU);
      if (tag_s2 == TAG_VGA) vga_data  <= ram_rdata;
      if (tag_s2 == TAG_CPU) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: vga fetches win every slot they ask for,
// the CPU takes the remaining slots. ARB_CONFLICT_CNT_EN builds conflict_cnt.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  vram_if.slave  bus
);

  logic              vga_pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              cpu_busy;
  ram_cmd_t          cmd_q;

  logic              vga_win_c;
  logic [ADDR_W-1:0] vga_addr_c;
  logic              cpu_elig_c;
  logic              cpu_grant_c;
  logic [TAG_W-1:0]  tag_c;

  // Slot winner for this cycle
  always_comb begin
    vga_win_c   = bus.vga_req | vga_pend;
    vga_addr_c  = bus.vga_req ? bus.vga_addr : pend_addr;
    cpu_elig_c  = bus.cpu_req & ~cpu_busy & ~bus.cpu_ack;
    cpu_grant_c = cpu_elig_c & ~vga_win_c;
    tag_c       = TAG_NONE;
    if (vga_win_c)                       tag_c = TAG_VGA;
    else if (cpu_grant_c && !bus.cpu_we) tag_c = TAG_CPU;
  end

  // A fetch strobe on the final reset cycle is remembered and served on release
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= '0;
      cpu_busy  <= 1'b0;
      vga_pend  <= bus.vga_req;
      pend_addr <= bus.vga_addr;
    end else begin
      vga_pend <= 1'b0;
      cmd_q.we <= cpu_grant_c & bus.cpu_we;
      if (vga_win_c) begin
        cmd_q.addr <= vga_addr_c;
      end else if (cpu_grant_c) begin
        cmd_q.addr  <= bus.cpu_addr;
        cmd_q.wdata <= bus.cpu_wdata;
      end
      if (cpu_grant_c)      cpu_busy <= 1'b1;
      else if (bus.cpu_ack) cpu_busy <= 1'b0;
    end
  end

  assign bus.ram_addr  = cmd_q.addr;
  assign bus.ram_we    = cmd_q.we;
  assign bus.ram_wdata = cmd_q.wdata;

  vram_rd_pipe u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag       (tag_c),
    .wr        (cpu_grant_c & bus.cpu_we),
    .ram_rdata (bus.ram_rdata),
    .vga_data  (bus.vga_data),
    .cpu_rdata (bus.cpu_rdata),
    .cpu_ack   (bus.cpu_ack)
  );

`ifdef ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts cycles where an eligible CPU request lost to vga; saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cpu_elig_c && vga_win_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.conflict_cnt = cnt_q;
`else
  assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a cycle-scheduled behavioural model.
module tb_vram_arbiter;

  logic clk;
  logic reset;
  vram_if bus_if ();

  vram_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM environment: write and read at the edge, data one cycle later
  logic [7:0] mem     [8192];
  logic [7:0] ref_mem [8192];

  always @(posedge clk) begin
    if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
    bus_if.ram_rdata <= mem[bus_if.ram_addr];
  end

  int nvec = 0;
  int nerr = 0;
  int unsigned mt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, mt);
    end
  endtask

  // Model: expected outputs scheduled by cycle from grant decisions
  logic        s_vga_v [8];
  logic [7:0]  s_vga_d [8];
  logic        s_rd_v  [8];
  logic [7:0]  s_rd_d  [8];
  logic        s_ack   [8];
  logic [12:0] m_addr, n_addr;
  logic        m_we,   n_we;
  logic [7:0]  m_wd,   n_wd;
  logic [15:0] m_cnt,  n_cnt;
  logic [7:0]  m_vga, m_rd;
  logic        m_ack;
  logic        zero_next = 1'b0;
  logic        seen_reset = 1'b0;
  int unsigned cpu_free = 0;

  always @(negedge clk) begin
    int unsigned k;
    logic        elig;
    k = mt % 8;
    m_addr = n_addr; m_we = n_we; m_wd = n_wd; m_cnt = n_cnt;
    if (zero_next) begin
      m_vga = '0; m_rd = '0; zero_next = 1'b0;
    end
    if (s_vga_v[k]) m_vga = s_vga_d[k];
    if (s_rd_v[k])  m_rd  = s_rd_d[k];
    m_ack = s_ack[k];
    s_vga_v[k] = 1'b0; s_rd_v[k] = 1'b0; s_ack[k] = 1'b0;

    if (seen_reset) begin
      chk("ram_addr",     32'(bus_if.ram_addr),     32'(m_addr));
      chk("ram_we",       32'(bus_if.ram_we),       32'(m_we));
      chk("ram_wdata",    32'(bus_if.ram_wdata),    32'(m_wd));
      chk("vga_data",     32'(bus_if.vga_data),     32'(m_vga));
      chk("cpu_rdata",    32'(bus_if.cpu_rdata),    32'(m_rd));
      chk("cpu_ack",      32'(bus_if.cpu_ack),      32'(m_ack));
      chk("conflict_cnt", 32'(bus_if.conflict_cnt), 32'(m_cnt));
    end

    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        s_vga_v[i] = 1'b0; s_rd_v[i] = 1'b0; s_ack[i] = 1'b0;
      end
      n_addr = '0; n_we = 1'b0; n_wd = '0; n_cnt = '0;
      zero_next  = 1'b1;
      seen_reset = 1'b1;
      cpu_free   = mt + 1;
    end else begin
      n_we = 1'b0;
      elig = bus_if.cpu_req && (mt >= cpu_free);
      if (bus_if.vga_req) begin
        n_addr = bus_if.vga_addr;
        s_vga_v[(k + 3) % 8] = 1'b1;
        s_vga_d[(k + 3) % 8] = ref_mem[bus_if.vga_addr];
`ifdef ARB_CONFLICT_CNT_EN
        if (elig && n_cnt != 16'hFFFF) n_cnt = n_cnt + 16'd1;
`endif
      end else if (elig) begin
        n_addr = bus_if.cpu_addr;
        n_wd   = bus_if.cpu_wdata;
        if (bus_if.cpu_we) begin
          n_we = 1'b1;
          ref_mem[bus_if.cpu_addr] = bus_if.cpu_wdata;
          s_ack[(k + 2) % 8] = 1'b1;
          cpu_free = mt + 3;
        end else begin
          s_ack[(k + 3) % 8]  = 1'b1;
          s_rd_v[(k + 3) % 8] = 1'b1;
          s_rd_d[(k + 3) % 8] = ref_mem[bus_if.cpu_addr];
          cpu_free = mt + 4;
        end
      end
    end
    mt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vga_fetch(input logic [12:0] a);
    bus_if.vga_req  = 1'b1;
    bus_if.vga_addr = a;
    step();
    bus_if.vga_req  = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [12:0] a, input logic [7:0] d,
                         output logic [7:0] rd);
    bit got;
    got = 1'b0;
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = we;
    bus_if.cpu_addr  = a;
    bus_if.cpu_wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (bus_if.cpu_ack === 1'b1) got = 1'b1;
    end
    bus_if.cpu_req = 1'b0;
    bus_if.cpu_we  = 1'b0;
    rd = bus_if.cpu_rdata;
    chk("cpu_ack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    bit         done;
    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[13'h1234]     = 8'hA5;
    ref_mem[13'h1234] = 8'hA5;

    reset = 1'b1;
    bus_if.vga_req = 1'b0; bus_if.vga_addr = '0;
    bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0;
    bus_if.cpu_addr = '0;  bus_if.cpu_wdata = '0;
    step(3);
    reset = 1'b0;
    step(10);
    chk("idle_ram_we",   32'(bus_if.ram_we),       32'd0);
    chk("idle_cpu_ack",  32'(bus_if.cpu_ack),      32'd0);
    chk("idle_vga_data", 32'(bus_if.vga_data),     32'd0);
    chk("idle_cnt",      32'(bus_if.conflict_cnt), 32'd0);

    // Single vga fetch with a 3-cycle latency
    vga_fetch(13'h1234);
    chk("fetch_ram_addr", 32'(bus_if.ram_addr), 32'h1234);
    step();
    chk("fetch_not_yet",  32'(bus_if.vga_data), 32'h00);
    step();
    chk("fetch_data",     32'(bus_if.vga_data), 32'hA5);
    step(5);
    chk("fetch_hold",     32'(bus_if.vga_data), 32'hA5);

    // CPU write then read-back
    cpu_txn(1'b1, 13'h0200, 8'h3C, rd);
    cpu_txn(1'b0, 13'h0200, 8'h00, rd);
    chk("cpu_read_back", 32'(rd), 32'h3C);
    step(3);

    // Simultaneous vga and CPU requests
    bus_if.vga_req = 1'b1; bus_if.vga_addr = 13'h0010;
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 13'h0020;
    step();
    bus_if.vga_req = 1'b0;
    chk("conflict_vga_addr", 32'(bus_if.ram_addr), 32'h0010);
    step();
    chk("conflict_cpu_addr", 32'(bus_if.ram_addr), 32'h0020);
    step();
    chk("conflict_vga_data", 32'(bus_if.vga_data), 32'h73);
    step();
    chk("conflict_cpu_ack",   32'(bus_if.cpu_ack),   32'd1);
    chk("conflict_cpu_rdata", 32'(bus_if.cpu_rdata), 32'hE3);
    bus_if.cpu_req = 1'b0;
    step();
`ifdef ARB_CONFLICT_CNT_EN
    chk("conflict_cnt_one", 32'(bus_if.conflict_cnt), 32'd1);
`else
    chk("conflict_cnt_off", 32'(bus_if.conflict_cnt), 32'd0);
`endif

    // Streaming: fetch every 16 cycles over two lines against back-to-back reads
    done = 1'b0;
    fork
      begin
        for (int l = 0; l < 2; l++)
          for (int f = 0; f < 10; f++) begin
            vga_fetch(13'($urandom));
            step(15);
          end
        done = 1'b1;
      end
      begin
        logic [7:0] r;
        while (!done) cpu_txn(1'b0, 13'($urandom), 8'h00, r);
      end
    join
    step(4);

    // Random mix of fetch spacings and CPU reads/writes on a small window
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 150; f++) begin
          vga_fetch(13'($urandom_range(0, 63)));
          step(int'($urandom_range(1, 7)));
        end
        done = 1'b1;
      end
      begin
        logic [7:0] r;
        while (!done) begin
          if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 3)));
          else cpu_txn(1'($urandom_range(0, 1)), 13'($urandom_range(0, 63)),
                       8'($urandom), r);
        end
      end
    join
    step(4);

    // Reset one cycle after a CPU read grant drops the read
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 13'h0200;
    step();
    bus_if.cpu_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_ram_addr",  32'(bus_if.ram_addr),     32'd0);
    chk("rst_ram_we",    32'(bus_if.ram_we),       32'd0);
    chk("rst_ram_wdata", 32'(bus_if.ram_wdata),    32'd0);
    chk("rst_vga_data",  32'(bus_if.vga_data),     32'd0);
    chk("rst_cpu_rdata", 32'(bus_if.cpu_rdata),    32'd0);
    chk("rst_cpu_ack",   32'(bus_if.cpu_ack),      32'd0);
    chk("rst_cnt",       32'(bus_if.conflict_cnt), 32'd0);
    step(5);
    cpu_txn(1'b0, 13'h0200, 8'h00, rd);
    chk("post_reset_read", 32'(rd), 32'h3C);
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM (8 KB, 13-bit address) between the vga scan-out fetch and the CPU bus.
- VGA fetches have fixed latency and absolute priority; the CPU gets every other cycle through a req/ack handshake.
- Sits between vga, the CPU bus glue and the vram block instance.

Parameters:
- ADDR_W, 13, RAM address width.
- DATA_W, 8, RAM data width.
- VGA_LAT, 3, cycles from vga_req to vga_data valid; fixed, documentation and check value only.

Ports:
- clk  in  1  system pixel clock.
- reset  in  1  synchronous active-high reset.
- vga_req  in  1  one-cycle fetch strobe from vga.
- vga_addr  in  ADDR_W  fetch address, sampled with vga_req.
- vga_data  out  DATA_W  last fetched byte, held until the next fetch.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU address, sampled at grant.
- cpu_wdata  in  DATA_W  write data, sampled at grant.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high, held after.
- cpu_ack  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr.
- conflict_cnt  out  16  deferred-CPU counter (see Optional Feature).

Behaviour:
- Reset: all registered outputs are 0 (ram_addr, ram_we, ram_wdata, vga_data, cpu_rdata, cpu_ack). vga_pend, cpu_busy and in-flight tags are cleared. A transaction in flight at reset is dropped with no cpu_ack.
- One RAM slot per cycle. In cycle N the arbiter picks a winner; its address, we and wdata are registered and presented in N+1. Read data returns in N+2 and is captured into the output register, visible in N+3.
- Priority: VGA (vga_req or vga_pend) beats CPU. The CPU is granted only when cpu_req=1, cpu_busy=0, cpu_ack=0 and no VGA request is present.
- VGA path: vga_req is always granted in the same cycle, so vga_data updates exactly VGA_LAT=3 cycles after vga_req. vga_pend exists only for the case where vga_req lands on a reset-release cycle; the newest address wins and there is no queue.
- CPU read: granted at M, ram_addr=cpu_addr at M+1, cpu_rdata loaded and cpu_ack=1 at M+3.
- CPU write: granted at M, ram_we=1 for exactly one cycle at M+1, cpu_ack=1 at M+2. cpu_rdata is unchanged.
- cpu_busy is set on grant and cleared with cpu_ack. There is no new grant in the ack cycle, so the requester may drop or re-present cpu_req at ack+1.
- Read tags: a 2-deep shift of {is_vga, is_cpu} steers ram_rdata to the correct output register.
- ram_we is 0 on every cycle that is not a CPU write slot. ram_addr holds its last value when the slot is idle.
- Simultaneous vga_req and cpu_req: VGA wins and the CPU is granted the next cycle (CPU deferral of exactly 1 cycle). The vga protocol guarantees vga_req spacing of at least 2 cycles, so worst-case CPU grant delay is 1 cycle.
- CPU address and data are not checked for range; the full 13 bits wrap naturally.

Optional Feature:
- Macro ARB_CONFLICT_CNT_EN.
- When defined: conflict_cnt increments by 1 on every cycle where the CPU was eligible but VGA won. It saturates at 16'hFFFF and clears on reset.
- When undefined: conflict_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package vram_pkg: ADDR_W/DATA_W defaults, VGA_LAT, and the read-tag encoding constants (TAG_NONE, TAG_VGA, TAG_CPU).
- One natural sub-module, vram_rd_pipe: the 2-stage tag shift plus the vga_data/cpu_rdata capture registers and cpu_ack generation.
- Arbitration and grant logic stay in the top module.

Test Plan:
- Reset, then idle 10 cycles: ram_we=0, cpu_ack=0, vga_data=0, conflict_cnt=0.
- RAM preloaded with 0x1234=8'hA5; vga_req with vga_addr=0x1234 at cycle 10: ram_addr=0x1234 at 11, vga_data=8'hA5 at 13 and held until the next fetch.
- cpu_req write 0x0200 <- 8'h3C granted at 20: ram_we=1 only at 21, cpu_ack at 22. Follow with a read of 0x0200: cpu_rdata=8'h3C with cpu_ack, 3 cycles after its grant.
- vga_req (addr 0x0010) and cpu_req read (addr 0x0020) in the same cycle 30: VGA address at 31, CPU address at 32, vga_data at 33, cpu_ack at 34. conflict_cnt=1 with ARB_CONFLICT_CNT_EN, 0 without.
- Streaming: vga_req every 16 cycles for 2 lines while the CPU issues back-to-back reads. Every vga_data arrives exactly 3 cycles after its vga_req, no CPU read returns the VGA byte, and every cpu_req gets exactly one cpu_ack.
- reset asserted the cycle after a CPU read grant: no cpu_ack, all outputs 0 next cycle; a request re-issued after reset completes normally.
